// File: rtl/taxi_gt_apb_seq_pkg.sv
// Shared types for the GT APB table sequencer.
// Entry layout, opcodes and FSM state encodings.
package taxi_gt_apb_seq_pkg;

  localparam int ENT_ADDR_W = 18;
  localparam int ENT_DATA_W = 16;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_RMW   = 2'd1,
    OP_POLL  = 2'd2,
    OP_END   = 2'd3
  } op_t;

  typedef struct packed {
    op_t                   op;
    logic [ENT_ADDR_W-1:0] addr;
    logic [ENT_DATA_W-1:0] data;
    logic [ENT_DATA_W-1:0] mask;
  } entry_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_APB_SETUP,
    ST_APB_ACCESS,
    ST_RMW_WR,
    ST_POLL_WAIT,
    ST_DONE,
    ST_ERROR
  } state_t;

  typedef enum logic [1:0] {
    E_IDLE,
    E_SETUP,
    E_ACCESS
  } eng_t;

  function automatic logic [ENT_DATA_W-1:0] merge(
    input logic [ENT_DATA_W-1:0] rd,
    input logic [ENT_DATA_W-1:0] data,
    input logic [ENT_DATA_W-1:0] mask
  );
    return (rd & ~mask) | (data & mask);
  endfunction

endpackage

// File: rtl/taxi_apb_if.sv
// APB bus bundle between a master and a completer.
// pstrb is byte-granular over pwdata.
interface taxi_apb_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0]   paddr;
  logic                psel;
  logic                penable;
  logic                pwrite;
  logic [DATA_W-1:0]   pwdata;
  logic [DATA_W/8-1:0] pstrb;
  logic [DATA_W-1:0]   prdata;
  logic                pready;
  logic                pslverr;

  modport mst (
    output paddr, psel, penable, pwrite, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slv (
    input  paddr, psel, penable, pwrite, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/taxi_gt_apb_seq_mst_eng.sv
// Single-access APB master engine with req/ack handshake.
// A new req on the ack cycle chains straight into the next setup.
module taxi_apb_mst_eng
  import taxi_gt_apb_seq_pkg::*;
#(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              slverr,
  taxi_apb_if.mst           m_apb
);

  eng_t              st_q, st_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;

  always_comb begin
    st_d      = st_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    ack       = 1'b0;
    unique case (st_q)
      E_IDLE: begin
        if (req) begin
          st_d     = E_SETUP;
          psel_d   = 1'b1;
          paddr_d  = req_addr;
          pwrite_d = req_wr;
          pwdata_d = req_wdata;
        end
      end
      E_SETUP: begin
        st_d      = E_ACCESS;
        penable_d = 1'b1;
      end
      E_ACCESS: begin
        if (m_apb.pready) begin
          ack       = 1'b1;
          penable_d = 1'b0;
          if (req) begin
            st_d     = E_SETUP;
            paddr_d  = req_addr;
            pwrite_d = req_wr;
            pwdata_d = req_wdata;
          end else begin
            st_d   = E_IDLE;
            psel_d = 1'b0;
          end
        end
      end
      default: begin
        st_d      = E_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q      <= E_IDLE;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
    end
  end

  assign m_apb.paddr   = paddr_q;
  assign m_apb.pwdata  = pwdata_q;
  assign m_apb.pwrite  = pwrite_q;
  assign m_apb.psel    = psel_q;
  assign m_apb.penable = penable_q;
  assign m_apb.pstrb   = '1;
  assign rdata         = m_apb.prdata;
  assign slverr        = m_apb.pslverr;

endmodule

// File: rtl/taxi_gt_apb_seq.sv
// Table-driven APB sequencer for GT DRP/control setup after reset.
// Define TAXI_GT_APB_SEQ_TIMEOUT_EN to bound the reads of each POLL entry.
module taxi_gt_apb_seq
  import taxi_gt_apb_seq_pkg::*;
#(
  parameter int ADDR_W        = ENT_ADDR_W,
  parameter int DATA_W        = ENT_DATA_W,
  parameter int TBL_AW        = 6,
  parameter int POLL_INTERVAL = 64,
  parameter int POLL_TIMEOUT  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [TBL_AW-1:0] err_idx,
  output logic [TBL_AW-1:0] tbl_addr,
  input  entry_t            tbl_data,
  taxi_apb_if.mst           m_apb
);

  localparam int WCW = $clog2(POLL_INTERVAL + 1);

  state_t            st_q, st_d;
  entry_t            ent_q, ent_d;
  logic [TBL_AW-1:0] idx_q, idx_d;
  logic [TBL_AW-1:0] eidx_q, eidx_d;
  logic [WCW-1:0]    wait_q, wait_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              rmw_wr_q, rmw_wr_d;

  logic              req, req_wr, ack, slverr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata, rdata;
  logic              poll_hit, rmw_rd, poll_miss;

`ifdef TAXI_GT_APB_SEQ_TIMEOUT_EN
  localparam int PCW = $clog2(POLL_TIMEOUT + 1);
  logic [PCW-1:0] pcnt_q, pcnt_d;
`endif

  assign poll_hit  = ((rdata ^ ent_q.data) & ent_q.mask) == '0;
  assign rmw_rd    = !slverr && ent_q.op == OP_RMW && !rmw_wr_q;
  assign poll_miss = !slverr && ent_q.op == OP_POLL && !poll_hit;

  always_comb begin
    st_d      = st_q;
    ent_d     = ent_q;
    idx_d     = idx_q;
    eidx_d    = eidx_q;
    wait_d    = wait_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    rmw_wr_d  = rmw_wr_q;
    req       = 1'b0;
    req_wr    = 1'b0;
    req_addr  = ent_q.addr;
    req_wdata = ent_q.data;
`ifdef TAXI_GT_APB_SEQ_TIMEOUT_EN
    pcnt_d    = pcnt_q;
`endif
    unique case (st_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          st_d   = ST_FETCH;
          idx_d  = '0;
          done_d = 1'b0;
          err_d  = 1'b0;
          busy_d = 1'b1;
        end
      end
      ST_FETCH: st_d = ST_EXEC;
      ST_EXEC: begin
        ent_d    = tbl_data;
        rmw_wr_d = 1'b0;
`ifdef TAXI_GT_APB_SEQ_TIMEOUT_EN
        pcnt_d   = '0;
`endif
        if (tbl_data.op == OP_END) begin
          st_d   = ST_DONE;
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          req       = 1'b1;
          req_wr    = tbl_data.op == OP_WRITE;
          req_addr  = tbl_data.addr;
          req_wdata = tbl_data.data;
          st_d      = ST_APB_SETUP;
        end
      end
      ST_APB_SETUP, ST_RMW_WR: st_d = ST_APB_ACCESS;
      ST_APB_ACCESS: begin
        if (ack) begin
          unique case (1'b1)
            slverr: begin
              st_d   = ST_ERROR;
              err_d  = 1'b1;
              busy_d = 1'b0;
              eidx_d = idx_q;
            end
            rmw_rd: begin
              req       = 1'b1;
              req_wr    = 1'b1;
              req_wdata = merge(rdata, ent_q.data, ent_q.mask);
              rmw_wr_d  = 1'b1;
              st_d      = ST_RMW_WR;
            end
            poll_miss: begin
              st_d   = ST_POLL_WAIT;
              wait_d = WCW'(POLL_INTERVAL);
`ifdef TAXI_GT_APB_SEQ_TIMEOUT_EN
              pcnt_d = pcnt_q + 1'b1;
              if (pcnt_q == PCW'(POLL_TIMEOUT - 1)) begin
                st_d   = ST_ERROR;
                err_d  = 1'b1;
                busy_d = 1'b0;
                eidx_d = idx_q;
              end
`endif
            end
            default: begin
              // last table slot finishes the run; the index never wraps
              if (&idx_q) begin
                st_d   = ST_DONE;
                busy_d = 1'b0;
                done_d = 1'b1;
              end else begin
                idx_d = idx_q + 1'b1;
                st_d  = ST_FETCH;
              end
            end
          endcase
        end
      end
      ST_POLL_WAIT: begin
        if (wait_q > WCW'(1)) begin
          wait_d = wait_q - 1'b1;
        end else begin
          wait_d = '0;
          req    = 1'b1;
          st_d   = ST_APB_SETUP;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q     <= ST_IDLE;
      ent_q    <= '0;
      idx_q    <= '0;
      eidx_q   <= '0;
      wait_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rmw_wr_q <= 1'b0;
`ifdef TAXI_GT_APB_SEQ_TIMEOUT_EN
      pcnt_q   <= '0;
`endif
    end else begin
      st_q     <= st_d;
      ent_q    <= ent_d;
      idx_q    <= idx_d;
      eidx_q   <= eidx_d;
      wait_q   <= wait_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rmw_wr_q <= rmw_wr_d;
`ifdef TAXI_GT_APB_SEQ_TIMEOUT_EN
      pcnt_q   <= pcnt_d;
`endif
    end
  end

  taxi_apb_mst_eng #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_eng (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_wr   (req_wr),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .ack      (ack),
    .rdata    (rdata),
    .slverr   (slverr),
    .m_apb    (m_apb)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = err_q;
  assign err_idx  = eidx_q;
  assign tbl_addr = idx_q;

endmodule
